mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. It shares the memory between the data path (port 0, MEM stage) and the instruction-refill path (port 1). It converts each requester's level read/write request into one registered memory transaction and tracks the memory's BUSYWAIT handshake. It stalls the losing requester and returns read data and completion to the winner.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- TIMEOUT, 64, maximum cycles in REQ before abort; 0 disables the timeout
- CLK  in  1  single clock, all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- P0_READ / P0_WRITE  in  1 each  port-0 request strobes, level, held until completion
- P0_FUNCT3  in  3  port-0 access size/sign code, passed through to memory
- P0_ADDRESS  in  ADDR_W  port-0 byte address
- P0_WRITEDATA  in  DATA_W  port-0 store data
- P0_READDATA  out  DATA_W  port-0 load result, registered
- P0_BUSYWAIT  out  1  port-0 stall
- P1_*  same set as P0_* for port 1
- M_READ / M_WRITE  out  1 each  memory strobes, registered
- M_FUNCT3, M_ADDRESS, M_WRITEDATA  out  3/ADDR_W/DATA_W  registered copy of the granted request
- M_READDATA  in  DATA_W  memory read data
- M_BUSYWAIT  in  1  memory busy
- GRANT  out  2  one-hot owner of the current transaction; 00 when idle
- TIMEOUT_ERR  out  1  one-cycle pulse on an aborted transaction

## Operation
- Valid request on port p: Pp_READ XOR Pp_WRITE. A port with both strobes high is invalid: it is never granted and its BUSYWAIT is 0.
- Pp_BUSYWAIT = valid(p) AND NOT (state==RESP AND GRANT[p]). This is combinational, so a new request stalls in the same cycle it is raised.
- FSM states and transitions:
  - IDLE to REQ: on any valid request, the winner is chosen.
  - REQ to RESP: on completion or timeout.
  - RESP to IDLE: always, after exactly one cycle.
- Arbitration uses round-robin with a last-served pointer LAST:
  - If only one port is valid, it wins.
  - If both are valid, the port not equal to LAST wins.
  - LAST resets to 1, so port 0 wins the first tie.
  - LAST updates to the winner on the RESP to IDLE transition.
- On the IDLE to REQ edge:
  - GRANT is set.
  - M_FUNCT3, M_ADDRESS and M_WRITEDATA are loaded from the winner.
  - M_READ/M_WRITE are loaded from the winner's strobes.
  - Cycle counter CNT is cleared to 0.
- In REQ:
  - CNT increments each cycle and saturates at TIMEOUT.
  - Completion is detected on a posedge where CNT >= 1 and M_BUSYWAIT == 0.
- On completion:
  - M_READ and M_WRITE drop to 0.
  - On a read, M_READDATA is latched into the granted port's READDATA; the other port's READDATA holds.
  - On a write, READDATA holds.
- On timeout (CNT == TIMEOUT - 1 with M_BUSYWAIT still 1, TIMEOUT != 0):
  - Strobes drop.
  - The granted READDATA is set to 0.
  - TIMEOUT_ERR is 1 during the following RESP cycle.
- In RESP: GRANT holds; the winner's BUSYWAIT is 0; the requester consumes its result and changes or drops its request at the closing edge.
- In IDLE: GRANT is 00 and all M_* strobes are 0.
- A requester that drops its request mid-transaction does not abort it. The transaction completes and its result is discarded by the requester.

## Timing
- Reset (RESET low, asynchronous):
  - State is IDLE; GRANT is 00 and LAST is 1.
  - M_READ, M_WRITE and TIMEOUT_ERR are 0.
  - M_FUNCT3, M_ADDRESS, M_WRITEDATA, P0_READDATA and P1_READDATA are 0.
  - CNT is 0.
  - A transaction in flight is abandoned and the memory strobes drop immediately.
  - After release, BUSYWAIT reflects only the live requests.
- Uncontended latency: a request sampled at edge 0 enters REQ at edge 0. The earliest completion is edge 2 and RESP is the cycle after it, so the minimum is 3 cycles from request to BUSYWAIT low.
- A contending port stays stalled through the full transaction of the other port plus one IDLE cycle.
- Back-to-back requests on the same port with no contention: IDLE lasts one cycle between RESP and the next REQ.
- Memory strobes are glitch-free registered outputs, stable for the whole REQ state. Requester inputs are sampled only at the IDLE to REQ edge.

## Test plan
- Single port-0 word read (FUNCT3=010), address 0x10, memory holding 0xDEADBEEF:
  - GRANT=01 and M_READ=1 for the REQ cycles.
  - P0_READDATA=0xDEADBEEF in RESP.
  - P0_BUSYWAIT low for exactly one cycle.
- Simultaneous requests, P0 write 0x12345678 to 0x20 and P1 read from 0x40, right after reset:
  - P0 is served first; P1 is stalled throughout and is then served.
  - LAST=1 at the end.
  - A second simultaneous pair then serves P0 first again.
- Port 0 requests continuously while port 1 requests intermittently: grants alternate whenever both are valid, so port 1 is never starved.
- Memory BUSYWAIT held high, TIMEOUT=8:
  - Abort after 8 REQ cycles.
  - TIMEOUT_ERR pulses one cycle and READDATA=0.
  - The FSM returns to IDLE.
- P1_READ and P1_WRITE both high: P1_BUSYWAIT=0, never granted, and no memory strobe.
- RESET low during REQ of a P0 read: M_READ=0 and GRANT=00 immediately, all outputs at reset values, and the request is re-served normally after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-ported data memory.
// Each winning level request becomes one registered memory transaction tracked through BUSYWAIT.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [2:0]        p0_funct3,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_writedata,
    output logic [DATA_W-1:0] p0_readdata,
    output logic              p0_busywait,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [2:0]        p1_funct3,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_writedata,
    output logic [DATA_W-1:0] p1_readdata,
    output logic              p1_busywait,
    output logic              m_read,
    output logic              m_write,
    output logic [2:0]        m_funct3,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_busywait,
    output logic [1:0]        grant,
    output logic              timeout_err
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'((TIMEOUT > 0) ? TIMEOUT : 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          grant_reg, grant_next;
    logic                last_reg, last_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                m_read_reg, m_read_next;
    logic                m_write_reg, m_write_next;
    logic [2:0]          m_funct3_reg, m_funct3_next;
    logic [ADDR_W-1:0]   m_address_reg, m_address_next;
    logic [DATA_W-1:0]   m_writedata_reg, m_writedata_next;
    logic [DATA_W-1:0]   rdata_reg [2];
    logic [DATA_W-1:0]   rdata_next [2];
    logic                timeout_err_reg, timeout_err_next;

    logic [1:0]          req_read, req_write, valid, busy;
    logic [2:0]          req_funct3 [2];
    logic [ADDR_W-1:0]   req_address [2];
    logic [DATA_W-1:0]   req_writedata [2];
    logic                winner, owner, done, expired;

    assign req_read         = {p1_read, p0_read};
    assign req_write        = {p1_write, p0_write};
    assign req_funct3[0]    = p0_funct3;
    assign req_funct3[1]    = p1_funct3;
    assign req_address[0]   = p0_address;
    assign req_address[1]   = p1_address;
    assign req_writedata[0] = p0_writedata;
    assign req_writedata[1] = p1_writedata;

    // A port with both strobes high is malformed: never granted, never stalled.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign valid[gi] = req_read[gi] ^ req_write[gi];
            assign busy[gi]  = valid[gi] && !(state_reg == RESP && grant_reg[gi]);
        end
    endgenerate

    assign winner  = (valid == 2'b11) ? ~last_reg : valid[1];
    assign owner   = grant_reg[1];
    assign done    = (cnt_reg != '0) && !m_busywait;
    assign expired = (TIMEOUT != 0) && m_busywait && (cnt_reg == CNT_LAST);

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_next        = last_reg;
        cnt_next         = cnt_reg;
        m_read_next      = m_read_reg;
        m_write_next     = m_write_reg;
        m_funct3_next    = m_funct3_reg;
        m_address_next   = m_address_reg;
        m_writedata_next = m_writedata_reg;
        rdata_next[0]    = rdata_reg[0];
        rdata_next[1]    = rdata_reg[1];
        timeout_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|valid) begin
                    state_next       = REQ;
                    grant_next       = winner ? 2'b10 : 2'b01;
                    m_read_next      = req_read[winner];
                    m_write_next     = req_write[winner];
                    m_funct3_next    = req_funct3[winner];
                    m_address_next   = req_address[winner];
                    m_writedata_next = req_writedata[winner];
                    cnt_next         = '0;
                end
            end
            REQ: begin
                if (done || expired) begin
                    state_next   = RESP;
                    m_read_next  = 1'b0;
                    m_write_next = 1'b0;
                    if (expired) begin
                        rdata_next[owner] = '0;
                        timeout_err_next  = 1'b1;
                    end else if (m_read_reg) begin
                        rdata_next[owner] = m_readdata;
                    end
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
                grant_next = 2'b00;
                last_next  = owner;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            grant_reg       <= 2'b00;
            last_reg        <= 1'b1;
            cnt_reg         <= '0;
            m_read_reg      <= 1'b0;
            m_write_reg     <= 1'b0;
            m_funct3_reg    <= '0;
            m_address_reg   <= '0;
            m_writedata_reg <= '0;
            rdata_reg[0]    <= '0;
            rdata_reg[1]    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_reg        <= last_next;
            cnt_reg         <= cnt_next;
            m_read_reg      <= m_read_next;
            m_write_reg     <= m_write_next;
            m_funct3_reg    <= m_funct3_next;
            m_address_reg   <= m_address_next;
            m_writedata_reg <= m_writedata_next;
            rdata_reg[0]    <= rdata_next[0];
            rdata_reg[1]    <= rdata_next[1];
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign p0_busywait = busy[0];
    assign p1_busywait = busy[1];
    assign p0_readdata = rdata_reg[0];
    assign p1_readdata = rdata_reg[1];
    assign m_read      = m_read_reg;
    assign m_write     = m_write_reg;
    assign m_funct3    = m_funct3_reg;
    assign m_address   = m_address_reg;
    assign m_writedata = m_writedata_reg;
    assign grant       = grant_reg;
    assign timeout_err = timeout_err_reg;
endmodule
